// File: rtl/counter_sequencer_pkg.sv
// Shared FSM state encodings and direction constants for the counter sequencer.
package counter_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_sequencer_updown_counter.sv
// WIDTH-bit up/down counter with synchronous load (load beats en); wraps modulo 2^WIDTH.
// Single-cycle: count updates on the edge where load or en is high.
module updown_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= up ? count + ONE : count - ONE;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer FSM around updown_counter: start/stop/pause, terminal detect, one-shot or auto-reload.
// Terminal hit N+1 edges after start; tick/done are registered one-cycle pulses.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             up_down,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [1:0]       state
);

   state_t           state_q;
   state_t           state_n;
   logic             cfg_up;
   logic             cfg_reload;
   logic [WIDTH-1:0] cfg_load;
   logic [WIDTH-1:0] cfg_term;
   logic             launch;
   logic             at_term;
   logic             ctr_load;
   logic [WIDTH-1:0] ctr_val;
   logic             ctr_en;
   logic             tick_n;
   logic             done_n;

   assign launch  = (state_q == ST_IDLE) && start && !stop;
   assign at_term = (count == cfg_term);
   assign busy    = (state_q != ST_IDLE);
   assign state   = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE: if (launch) state_n = ST_RUN;
         ST_RUN: begin
            if (stop)                         state_n = ST_IDLE;
            else if (pause)                   state_n = ST_HOLD;
            else if (at_term && !cfg_reload)  state_n = ST_DONE;
         end
         ST_HOLD: begin
            if (stop)        state_n = ST_IDLE;
            else if (!pause) state_n = ST_RUN;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Counter controls and pulse requests; only RUN with no stop/pause moves the count.
   always_comb begin
      ctr_load = 1'b0;
      ctr_val  = cfg_load;
      ctr_en   = 1'b0;
      tick_n   = 1'b0;
      done_n   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               ctr_load = 1'b1;
               ctr_val  = load_val;
            end
         end
         ST_RUN: begin
            if (!stop && !pause) begin
               if (at_term) begin
                  tick_n = 1'b1;
                  if (cfg_reload) ctr_load = 1'b1;
                  else            done_n   = 1'b1;
               end else begin
                  ctr_en = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_up     <= 1'b0;
         cfg_reload <= 1'b0;
         cfg_load   <= '0;
         cfg_term   <= '0;
         tick       <= 1'b0;
         done       <= 1'b0;
      end else begin
         tick <= tick_n;
         done <= done_n;
         if (launch) begin
            cfg_up     <= up_down;
            cfg_reload <= auto_reload;
            cfg_load   <= load_val;
            cfg_term   <= term_val;
         end
      end
   end

   updown_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (ctr_load),
      .load_val (ctr_val),
      .en       (ctr_en),
      .up       (cfg_up == DIR_UP),
      .count    (count)
   );

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized and directed checks of counter_sequencer against a behavioural model.
module tb_counter_sequencer;

   localparam int W = 3;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         pause = 1'b0;
   logic         up_down = 1'b0;
   logic         auto_reload = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] term_val = '0;
   logic [W-1:0] count;
   logic         busy;
   logic         tick;
   logic         done;
   logic [1:0]   state;

   int n_checks = 0;
   int n_errors = 0;

   // Model: phase 0 idle, 1 running, 2 paused, 3 finishing
   int m_st, m_cnt, m_ld, m_tm;
   bit m_up, m_ar, m_tick, m_done;

   counter_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .up_down(up_down), .auto_reload(auto_reload), .load_val(load_val),
      .term_val(term_val), .count(count), .busy(busy), .tick(tick),
      .done(done), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_ld = 0; m_tm = 0;
      m_up = 0; m_ar = 0; m_tick = 0; m_done = 0;
   endtask

   task automatic model_edge();
      m_tick = 0;
      m_done = 0;
      if (m_st == 0) begin
         if (start && !stop) begin
            m_cnt = int'(load_val); m_ld = int'(load_val); m_tm = int'(term_val);
            m_up = up_down; m_ar = auto_reload; m_st = 1;
         end
      end else if (m_st == 3) begin
         m_st = 0;
      end else if (stop) begin
         m_st = 0;
      end else if (m_st == 2) begin
         if (!pause) m_st = 1;
      end else if (pause) begin
         m_st = 2;
      end else if (m_cnt == m_tm) begin
         m_tick = 1;
         if (m_ar) m_cnt = m_ld;
         else begin m_done = 1; m_st = 3; end
      end else begin
         m_cnt = m_up ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
      end
   endtask

   task automatic compare_all();
      chk("count", int'(count), m_cnt);
      chk("state", int'(state), m_st);
      chk("busy",  int'(busy),  (m_st != 0) ? 1 : 0);
      chk("tick",  int'(tick),  int'(m_tick));
      chk("done",  int'(done),  int'(m_done));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1 compare_all();
      @(negedge clk);
   endtask

   task automatic setin(input bit s, input bit sp, input bit p, input bit ud,
                        input bit ar, input int lv, input int tv);
      start = s; stop = sp; pause = p; up_down = ud; auto_reload = ar;
      load_val = W'(lv); term_val = W'(tv);
   endtask

   initial begin
      model_reset();
      #3 compare_all();
      @(negedge clk);
      rst = 1'b0;
      step();

      // One-shot up 2 -> 5
      setin(1, 0, 0, 1, 0, 2, 5);
      step();
      chk("t1_load", int'(count), 2);
      start = 0;
      repeat (3) step();
      chk("t1_at_term", int'(count), 5);
      step();
      chk("t1_tick", int'(tick), 1);
      chk("t1_done", int'(done), 1);
      chk("t1_state_done", int'(state), 3);
      step();
      chk("t1_idle", int'(state), 0);
      chk("t1_busy", int'(busy), 0);
      chk("t1_hold_cnt", int'(count), 5);

      // Auto-reload up 6 -> 1
      setin(1, 0, 0, 1, 1, 6, 1);
      step();
      start = 0;
      repeat (13) step();
      stop = 1; step(); stop = 0;

      // One-shot down 1 -> 6
      setin(1, 0, 0, 0, 0, 1, 6);
      step();
      start = 0;
      repeat (3) step();
      chk("t3_at_term", int'(count), 6);
      repeat (2) step();

      // start and stop together in IDLE
      setin(1, 1, 0, 1, 0, 3, 4);
      step();
      chk("t4_stay_idle", int'(state), 0);
      setin(0, 0, 0, 1, 0, 3, 4);

      // Pause, resume, restart attempt, stop
      setin(1, 0, 0, 1, 1, 0, 7);
      step();
      start = 0;
      repeat (2) step();
      pause = 1;
      repeat (3) step();
      chk("t5_hold", int'(state), 2);
      pause = 0;
      repeat (3) step();
      setin(1, 0, 0, 0, 0, 5, 5);
      step();
      start = 0;
      stop = 1; step(); stop = 0;
      step();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         start       = ($urandom_range(0, 9) < 3);
         stop        = ($urandom_range(0, 19) == 0);
         pause       = ($urandom_range(0, 9) < 2);
         up_down     = 1'($urandom);
         auto_reload = 1'($urandom);
         load_val    = W'($urandom);
         term_val    = W'($urandom);
         step();
      end

      // Asynchronous reset mid-run
      setin(1, 0, 0, 1, 1, 3, 2);
      step();
      start = 0;
      repeat (2) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_state", int'(state), 0);
      chk("arst_busy",  int'(busy), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
